// File: rtl/aes_job_scheduler_if.sv
// Requester/consumer bundle for aes_job_scheduler: job requests in, tagged ciphertext responses out.
// The scheduler binds the slave modport; requesters and the response consumer use master.
interface aes_job_scheduler_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]     req;
    logic [NREQ*128-1:0] req_data;
    logic [NREQ-1:0]     ack;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [127:0]        resp_data;
    logic                resp_err;

    modport master (
        output req, req_data, resp_ready,
        input  ack, resp_valid, resp_id, resp_data, resp_err
    );

    modport slave (
        input  req, req_data, resp_ready,
        output ack, resp_valid, resp_id, resp_data, resp_err
    );
endinterface

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: round-robin time-sharing of one AES core between NREQ requesters.
// Define AES_SCHED_TIMEOUT_EN to build the RUN-state watchdog (TIMEOUT_CYCLES).
module aes_job_scheduler #(
    parameter int NREQ           = 4,
    parameter int ID_W           = 2,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_ready,
    aes_job_scheduler_if.slave bus,
    output logic               core_rst,
    output logic [127:0]       core_data_in,
    input  logic               core_done,
    input  logic [127:0]       core_data_out,
    output logic               busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;
    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

    logic [1:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] next_ptr;
    logic [3:0]      rst_cnt;
    logic            pick_valid;
    logic            timeout_hit;
    logic            abort;
    logic [NREQ-1:0] rotated;
    logic [127:0]    pick_data;
    int              slot;

    // Rotate req so bit 0 is the requester at rr_ptr; the lowest set bit of the rotation wins.
    always_comb begin
        rotated    = NREQ'({bus.req, bus.req} >> rr_ptr);
        pick_valid = 1'b0;
        pick_id    = '0;
        slot       = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_valid && rotated[k]) begin
                pick_valid = 1'b1;
                slot       = int'(rr_ptr) + k;
                if (slot >= NREQ) slot = slot - NREQ;
                pick_id    = ID_W'(slot);
            end
        end
        pick_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_id == ID_W'(k)) pick_data = bus.req_data[128*k +: 128];
        end
        next_ptr = (int'(pick_id) == NREQ - 1) ? '0 : pick_id + 1'b1;
    end

`ifdef AES_SCHED_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!reset || state != RUN) tmo_cnt <= '0;
        else                        tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign timeout_hit = (state == RUN) && !core_done && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Key loss (or watchdog expiry) while the core owns the job turns it into an error response.
    assign abort = ((state == LOAD) || (state == RUN)) && (!key_ready || timeout_hit);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            bus.ack        <= '0;
            core_rst       <= 1'b1;
            core_data_in   <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= '0;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
            rr_ptr         <= '0;
            cur_id         <= '0;
            rst_cnt        <= '0;
        end else begin
            bus.ack <= '0;
            if (abort) begin
                core_rst       <= 1'b1;
                bus.resp_valid <= 1'b1;
                bus.resp_err   <= 1'b1;
                bus.resp_data  <= '0;
                bus.resp_id    <= cur_id;
                state          <= RESP;
            end else begin
                case (state)
                    IDLE: begin
                        core_rst <= 1'b1;
                        if (key_ready && pick_valid) begin
                            core_data_in <= pick_data;
                            cur_id       <= pick_id;
                            bus.ack      <= NREQ'(1) << pick_id;
                            rr_ptr       <= next_ptr;
                            rst_cnt      <= '0;
                            state        <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (rst_cnt == RST_LAST) begin
                            core_rst <= 1'b0;
                            state    <= RUN;
                        end else begin
                            rst_cnt <= rst_cnt + 4'd1;
                        end
                    end
                    RUN: begin
                        if (core_done) begin
                            bus.resp_data  <= core_data_out;
                            bus.resp_id    <= cur_id;
                            bus.resp_err   <= 1'b0;
                            bus.resp_valid <= 1'b1;
                            state          <= RESP;
                        end
                    end
                    RESP: begin
                        if (bus.resp_valid && bus.resp_ready) begin
                            bus.resp_valid <= 1'b0;
                            core_rst       <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
